// File: rtl/move_line_parser.sv
// move_line_parser: decodes "L68\n"-style ASCII move lines into paced (direction, count) pulses.
module move_line_parser #(
    parameter int INPUT_WIDTH = 10,
    parameter int PACE_EXTRA  = 1,
    parameter int CNT_WIDTH   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   valid,
    output logic                   step_direction,
    output logic [INPUT_WIDTH-1:0] step_count,
    output logic                   busy,
    output logic                   err,
    output logic [CNT_WIDTH-1:0]   lines_out
);
    localparam logic [2:0] IDLE = 3'd0, DIGITS = 3'd1, SKIP = 3'd2, EMIT = 3'd3, PACE = 3'd4;
    localparam int AW = INPUT_WIDTH + 4;
    localparam int PW = INPUT_WIDTH + $clog2(PACE_EXTRA + 1) + 1;
    logic [2:0]             state;
    logic [INPUT_WIDTH-1:0] acc;
    logic                   dir;
    logic                   seen;
    logic [PW-1:0]          pace;
    logic                   take;
    logic                   is_digit;
    logic                   is_eol;
    logic                   is_dir;
    logic                   is_blank;
    logic [AW-1:0]          acc_next;
    logic                   overflow;
    assign take     = in_valid & in_ready;
    assign is_digit = (in_data >= "0") && (in_data <= "9");
    assign is_eol   = (in_data == 8'h0A) || (in_data == 8'h0D);
    assign is_dir   = (in_data == "L") || (in_data == "R");
    assign is_blank = is_eol || (in_data == " ");
    assign acc_next = AW'(acc) * AW'(10) + AW'(in_data[3:0]);
    assign overflow = |acc_next[AW-1:INPUT_WIDTH];
    assign in_ready = !rst && (state == IDLE || state == DIGITS || state == SKIP);
    assign valid    = state == EMIT;
    assign busy     = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            acc            <= '0;
            dir            <= 1'b0;
            seen           <= 1'b0;
            pace           <= '0;
            step_direction <= 1'b0;
            step_count     <= '0;
            err            <= 1'b0;
            lines_out      <= '0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    if (is_dir) begin
                        dir   <= in_data == "R";
                        acc   <= '0;
                        seen  <= 1'b0;
                        state <= in_last ? IDLE : DIGITS;
                    end else if (!is_blank) begin
                        err   <= 1'b1;
                        state <= in_last ? IDLE : SKIP;
                    end
                end
                DIGITS: if (take) begin
                    if (is_digit && overflow) begin
                        err   <= 1'b1;
                        state <= in_last ? IDLE : SKIP;
                    end else if (is_digit) begin
                        acc  <= acc_next[INPUT_WIDTH-1:0];
                        seen <= 1'b1;
                        // a digit carrying in_last closes the final line without a newline
                        if (in_last) begin
                            step_count     <= acc_next[INPUT_WIDTH-1:0];
                            step_direction <= dir;
                            state          <= EMIT;
                        end
                    end else if (is_eol && seen) begin
                        step_count     <= acc;
                        step_direction <= dir;
                        state          <= EMIT;
                    end else if (is_eol) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        err   <= 1'b1;
                        state <= in_last ? IDLE : SKIP;
                    end
                end
                SKIP: if (take && (in_data == 8'h0A || in_last)) state <= IDLE;
                EMIT: begin
                    lines_out <= lines_out + 1'b1;
                    pace      <= PW'(acc) + PW'(PACE_EXTRA);
                    state     <= (acc == '0 && PACE_EXTRA == 0) ? IDLE : PACE;
                end
                PACE: begin
                    pace  <= pace - 1'b1;
                    state <= (pace <= PW'(1)) ? IDLE : PACE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_line_parser.sv
// tb_move_line_parser: scoreboard bench; stimulus queues expected pulses, a monitor checks them and their spacing.
module tb_move_line_parser;
    localparam int IW = 10;
    localparam int PE = 1;
    localparam int CW = 12;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          valid;
    logic          step_direction;
    logic [IW-1:0] step_count;
    logic          busy;
    logic          err;
    logic [CW-1:0] lines_out;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_cyc;
    int            last_n;
    bit            have_last = 0;
    logic [IW:0]   exp_q[$];

    move_line_parser #(.INPUT_WIDTH(IW), .PACE_EXTRA(PE), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .valid(valid), .step_direction(step_direction),
        .step_count(step_count), .busy(busy), .err(err), .lines_out(lines_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) have_last = 0;
        else if (valid) begin
            logic [IW:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse: unexpected pulse dir=%0d count=%0d", step_direction, step_count);
            end else begin
                e = exp_q.pop_front();
                if ({step_direction, step_count} !== e) begin
                    errors++;
                    $display("FAIL pulse: got dir=%0d count=%0d, expected dir=%0d count=%0d",
                             step_direction, step_count, e[IW], e[IW-1:0]);
                end
            end
            if (have_last) begin
                checks++;
                if (cyc - last_cyc < last_n + 1 + PE) begin
                    errors++;
                    $display("FAIL spacing: got %0d cycles, need at least %0d", cyc - last_cyc, last_n + 1 + PE);
                end
            end
            have_last = 1;
            last_cyc  = cyc;
            last_n    = int'(step_count);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        int n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("send_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last_final);
        for (int i = 0; i < s.len(); i++) send(s[i], last_final && (i == s.len() - 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        check("reset_lines", lines_out, 0);
        check("reset_count", step_count, 0);
        check("reset_dir", step_direction, 0);
    endtask

    task automatic drain(input string name, input int lines, input int e);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, n < 3000, 1);
        check({name, "_lines"}, lines_out, lines);
        check({name, "_err"}, err, e);
    endtask

    initial begin
        int n;
        @(negedge clk);
        do_reset();
        exp_q.push_back({1'b1, 10'd48});
        send_str("R48\n", 0);
        drain("r48", 1, 0);

        do_reset();
        exp_q.push_back({1'b0, 10'd68});
        exp_q.push_back({1'b0, 10'd30});
        exp_q.push_back({1'b1, 10'd48});
        send_str("L68\nL30\nR48\n", 0);
        drain("three", 3, 0);

        do_reset();
        exp_q.push_back({1'b1, 10'd1023});
        send_str("R1023\n", 0);
        drain("max", 1, 0);

        do_reset();
        exp_q.push_back({1'b0, 10'd5});
        send_str("R1024\nL5\n", 0);
        drain("overflow", 1, 1);

        do_reset();
        exp_q.push_back({1'b1, 10'd3});
        send_str("X12\nR3\n", 0);
        drain("badchar", 1, 1);

        do_reset();
        exp_q.push_back({1'b1, 10'd3});
        send_str("L\nR3\n", 0);
        drain("nodigits", 1, 1);

        do_reset();
        exp_q.push_back({1'b0, 10'd0});
        send_str("L0\n", 0);
        check("zero_valid", valid, 1);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("zero_idle_cycles", n, PE + 1);
        drain("zero", 1, 0);

        do_reset();
        exp_q.push_back({1'b0, 10'd7});
        exp_q.push_back({1'b1, 10'd7});
        send_str(" \r\nL007\n", 0);
        send_str("R7", 1);
        drain("last", 2, 0);

        do_reset();
        send_str("R4", 0);
        do_reset();
        exp_q.push_back({1'b0, 10'd2});
        send_str("L2\n", 0);
        drain("midreset", 1, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
